spike_frame_serializer: RTL and testbench

- Downstream sink for a dense layer's wide output frame. It accepts one NUM_ELEMS×DATA_WIDTH frame per valid/ready handshake, then emits the frame one int8 element per handshake on a narrow stream.
- While streaming, it tracks the signed maximum and its index, giving the classifier decision (argmax) at end of frame.
- It sits between the last dense_layer (o_valid/o_ready/o_spikes) and the result/UART/readout logic.

---
 rtl/spike_frame_serializer_pkg.sv | 28 ++
 rtl/spike_frame_serializer_if.sv | 34 +++
 rtl/argmax_tracker.sv | 41 ++++
 rtl/spike_frame_serializer.sv | 97 +++++++++
 tb/tb_spike_frame_serializer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_frame_serializer_pkg.sv
// Shared definitions for the spike frame serializer: state encodings,
// index-width helper and the valid/ready handshake helper.
package spike_frame_serializer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StStream = 2'd1;
    localparam state_t StReport = 2'd2;

    // Ceiling log2, never less than 1 so that index ports always have a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // A valid/ready transfer, the same handshake rule the dense layer uses.
    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/spike_frame_serializer_if.sv
// Frame input, element stream output and argmax result of the serializer.
interface spike_frame_serializer_if
    import spike_frame_serializer_pkg::*;
#(
    parameter int unsigned NUM_ELEMS  = 256,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = clog2(NUM_ELEMS)
);

    logic                            i_valid;
    logic                            i_ready;
    logic [NUM_ELEMS*DATA_WIDTH-1:0] i_spikes;
    logic                            o_valid;
    logic                            o_ready;
    logic [DATA_WIDTH-1:0]           o_data;
    logic [IDX_WIDTH-1:0]            o_index;
    logic                            o_last;
    logic                            argmax_valid;
    logic [IDX_WIDTH-1:0]            argmax_idx;
    logic [DATA_WIDTH-1:0]           argmax_val;

    modport master (
        output i_valid, i_spikes, o_ready,
        input  i_ready, o_valid, o_data, o_index, o_last,
        input  argmax_valid, argmax_idx, argmax_val
    );

    modport slave (
        input  i_valid, i_spikes, o_ready,
        output i_ready, o_valid, o_data, o_index, o_last,
        output argmax_valid, argmax_idx, argmax_val
    );

endinterface

// File: rtl/argmax_tracker.sv
// Running signed maximum over a stream; strictly-greater replaces, so ties keep
// the lowest index. The first update after init always loads.
module argmax_tracker #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  update_en,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [IDX_WIDTH-1:0]  index,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [IDX_WIDTH-1:0]  max_idx
);

    logic                  have_q;
    logic [DATA_WIDTH-1:0] max_val_q;
    logic [IDX_WIDTH-1:0]  max_idx_q;
    logic                  take;

    assign take = update_en && (!have_q || ($signed(value) > $signed(max_val_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_q    <= 1'b0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else if (init) begin
            have_q <= 1'b0;
        end else if (take) begin
            have_q    <= 1'b1;
            max_val_q <= value;
            max_idx_q <= index;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule

// File: rtl/spike_frame_serializer.sv
// Captures one wide frame, streams it out element by element and reports the
// signed argmax of the frame one cycle after the last element.
module spike_frame_serializer
    import spike_frame_serializer_pkg::*;
#(
    parameter int unsigned NUM_ELEMS  = 256,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = clog2(NUM_ELEMS)
) (
    input logic                     clk,
    input logic                     rst,
    spike_frame_serializer_if.slave bus
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_ELEMS - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] frame_q [NUM_ELEMS];
    logic [IDX_WIDTH-1:0]  cnt_q;
    logic [IDX_WIDTH-1:0]  argmax_idx_q;
    logic [DATA_WIDTH-1:0] argmax_val_q;
    logic [IDX_WIDTH-1:0]  trk_idx;
    logic [DATA_WIDTH-1:0] trk_val;
    logic                  accept;
    logic                  out_fire;
    logic                  is_last;

    assign accept   = fire(bus.i_valid, state_q == StIdle);
    assign out_fire = fire(state_q == StStream, bus.o_ready);
    assign is_last  = (cnt_q == LastIdx);

    assign bus.i_ready      = (state_q == StIdle);
    assign bus.o_valid      = (state_q == StStream);
    assign bus.o_data       = frame_q[cnt_q];
    assign bus.o_index      = cnt_q;
    assign bus.o_last       = (state_q == StStream) && is_last;
    assign bus.argmax_valid = (state_q == StReport);
    // The tracker already holds the final result during REPORT; afterwards the
    // held copy keeps it stable while the next frame streams.
    assign bus.argmax_idx   = (state_q == StReport) ? trk_idx : argmax_idx_q;
    assign bus.argmax_val   = (state_q == StReport) ? trk_val : argmax_val_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StStream;
            StStream: if (out_fire && is_last) state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            argmax_idx_q <= '0;
            argmax_val_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
            end else if (out_fire && !is_last) begin
                cnt_q <= cnt_q + IDX_WIDTH'(1);
            end
            if (state_q == StReport) begin
                argmax_idx_q <= trk_idx;
                argmax_val_q <= trk_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ELEMS; k++) frame_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_ELEMS; k++) begin
                frame_q[k] <= bus.i_spikes[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    argmax_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .init      (accept),
        .update_en (out_fire),
        .value     (bus.o_data),
        .index     (cnt_q),
        .max_val   (trk_val),
        .max_idx   (trk_idx)
    );

endmodule

// File: tb/tb_spike_frame_serializer.sv
// Scoreboard bench for spike_frame_serializer with a 4-element frame.
module tb_spike_frame_serializer;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } elem_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spike_frame_serializer_if #(.NUM_ELEMS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    spike_frame_serializer #(
        .NUM_ELEMS  (N),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    elem_t eq[$];
    res_t  rq[$];
    res_t  hold;
    bit    pending_report;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    int    ready_mode = 0;
    int    pat_i = 0;
    bit    pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: first strictly-greater signed element wins.
    function automatic res_t ref_argmax(input logic [N*DW-1:0] s);
        res_t r;
        int   best;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if ($signed(s[k*DW +: DW]) > $signed(s[best*DW +: DW])) best = k;
        end
        r.idx = IW'(best);
        r.val = s[best*DW +: DW];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Monitor: compares every DUT-presented output against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("i_ready", {31'd0, bus.i_ready}, {31'd0, (eq.size() == 0 && !pending_report)});
            check("argmax_valid", {31'd0, bus.argmax_valid}, {31'd0, pending_report});
            if (pending_report) begin
                if (rq.size() != 0) hold = rq.pop_front();
                pending_report = 1'b0;
            end
            check("argmax_idx", {30'd0, bus.argmax_idx}, {30'd0, hold.idx});
            check("argmax_val", {24'd0, bus.argmax_val}, {24'd0, hold.val});
            if (bus.o_valid) begin
                if (eq.size() == 0) begin
                    check("o_valid_spurious", 32'd1, 32'd0);
                end else begin
                    check("o_data", {24'd0, bus.o_data}, {24'd0, eq[0].data});
                    check("o_index", {30'd0, bus.o_index}, {30'd0, eq[0].idx});
                    check("o_last", {31'd0, bus.o_last}, {31'd0, eq[0].last});
                    if (bus.o_ready) begin
                        if (eq[0].last) begin
                            pending_report = 1'b1;
                            last_hs_cyc = cyc + 1;
                        end
                        void'(eq.pop_front());
                    end
                end
            end else begin
                check("o_valid", {31'd0, bus.o_valid}, {31'd0, (eq.size() != 0)});
                check("o_last_idle", {31'd0, bus.o_last}, 32'd0);
            end
        end
    end

    initial begin
        bus.o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.o_ready = 1'b1;
                1: begin
                    bus.o_ready = (pat_i < 7) ? pat[pat_i] : 1'b1;
                    pat_i++;
                end
                default: bus.o_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_frame(input logic [N*DW-1:0] s, input bit keep_valid, input bit b2b);
        bit    ok;
        int    acc;
        elem_t e;
        ok = 1'b0;
        bus.i_spikes = s;
        bus.i_valid  = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.i_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.i_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            e.data = s[k*DW +: DW];
            e.idx  = IW'(k);
            e.last = (k == N - 1);
            eq.push_back(e);
        end
        rq.push_back(ref_argmax(s));
        pat_i = 0;
        if (b2b) check("b2b_gap", acc - last_hs_cyc, 32'd2);
        if (!keep_valid) begin
            #1;
            bus.i_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk);
            #2;
            if (eq.size() == 0 && !pending_report) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [N*DW-1:0] s;
        bit reached;
        rst = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_spikes = '0;
        hold = '0;
        pending_report = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_argmax_valid", {31'd0, bus.argmax_valid}, 32'd0);
        check("rst_argmax_idx", {30'd0, bus.argmax_idx}, 32'd0);
        check("rst_argmax_val", {24'd0, bus.argmax_val}, 32'd0);

        ready_mode = 0;
        send_frame(pack4(3, -5, 7, 7), 1'b0, 1'b0);
        wait_drain();

        ready_mode = 1;
        send_frame(pack4(3, -5, 7, 7), 1'b0, 1'b0);
        wait_drain();

        ready_mode = 0;
        send_frame(pack4(-128, -128, -128, -128), 1'b0, 1'b0);
        wait_drain();
        send_frame(pack4(-1, -128, 0, 127), 1'b0, 1'b0);
        wait_drain();

        // Upstream keeps i_valid up and scribbles on i_spikes while streaming.
        send_frame(pack4(10, 20, -30, 20), 1'b1, 1'b0);
        for (int t = 0; t < 200 && (eq.size() != 0 || pending_report); t++) begin
            @(posedge clk);
            #2;
            if (eq.size() != 0 || pending_report) bus.i_spikes = N*DW'($urandom);
        end
        send_frame(pack4(-7, 5, 5, -7), 1'b0, 1'b1);
        wait_drain();

        // Abort mid-frame after two elements have been handed over.
        ready_mode = 0;
        send_frame(pack4(9, 8, 100, 6), 1'b0, 1'b0);
        reached = 1'b0;
        for (int t = 0; t < 50 && !reached; t++) begin
            @(posedge clk);
            #1;
            if (eq.size() <= 2) reached = 1'b1;
        end
        check("abort_reached", {31'd0, reached}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("abort_argmax_valid", {31'd0, bus.argmax_valid}, 32'd0);
        eq.delete();
        rq.delete();
        pending_report = 1'b0;
        hold = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send_frame(pack4(1, 2, 3, 4), 1'b0, 1'b0);
        wait_drain();

        ready_mode = 2;
        for (int f = 0; f < 24; f++) begin
            for (int k = 0; k < N; k++) begin
                if (f % 2 == 0) s[k*DW +: DW] = DW'($urandom);
                else            s[k*DW +: DW] = DW'($urandom_range(0, 3) - 2);
            end
            send_frame(s, 1'b0, 1'b0);
            if (f % 3 == 0) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
